// File: rtl/io_bridge_pkg.sv
// Shared sizing helpers for the I/O port bridge and its output FIFO.
package io_bridge_pkg;

    localparam int NUBITS_DEF = 16;
    localparam int NBIOIN_DEF = 2;
    localparam int NBIOOU_DEF = 2;
    localparam int ODEPTH_DEF = 4;

    // Output FIFO entries carry the port tag above the data word.
    function automatic int entry_width(input int nbioou, input int nubits);
        return nbioou + nubits;
    endfunction

    function automatic int fresh_width(input int nbioin);
        return 1 << nbioin;
    endfunction

endpackage

// File: rtl/io_bridge_fifo.sv
// Synchronous FIFO with count/full/empty and a registered head entry.
// A push is accepted while full if a pop frees a slot in the same cycle.
module io_bridge_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = head_q;
    assign count_o = count_q;

    // The head is precomputed from next-state pointers so it can be a register.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (count_d == '0)
            head_d = '0;
        else if (do_push && (wr_ptr_q == rd_ptr_d))
            head_d = push_data_i;
        else
            head_d = mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/io_bridge.sv
// Processor I/O port responder: OUT writes drain through a FIFO, INN reads hit holding registers.
// Optional interrupt pulse on each accepted inbound word when IO_BRIDGE_ITR_EN is defined.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int NUBITS  = NUBITS_DEF,
    parameter int NBIOIN  = NBIOIN_DEF,
    parameter int NBIOOU  = NBIOOU_DEF,
    parameter int ODEPTH  = ODEPTH_DEF,
    localparam int NPORT  = fresh_width(NBIOIN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUBITS-1:0] io_out,
    input  logic [NBIOOU-1:0] addr_out,
    input  logic              out_en,
    output logic [NUBITS-1:0] io_in,
    input  logic [NBIOIN-1:0] addr_in,
    input  logic              req_in,
    output logic [NUBITS-1:0] m_data,
    output logic [NBIOOU-1:0] m_addr,
    output logic              m_valid,
    input  logic              m_ready,
    input  logic [NUBITS-1:0] s_data,
    input  logic [NBIOIN-1:0] s_addr,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [NPORT-1:0]  fresh,
    output logic              ovf,
    output logic              itr
);

    localparam int EW = entry_width(NBIOOU, NUBITS);
    localparam int CW = $clog2(ODEPTH + 1);

    logic [EW-1:0]     fifo_head;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full, fifo_empty, fifo_pop, fifo_drop;
    logic              ovf_q;
    logic [NUBITS-1:0] hold_q [NPORT];
    logic [NUBITS-1:0] hold_d [NPORT];
    logic [NPORT-1:0]  fresh_q, fresh_d;
    logic              s_fire;

    io_bridge_fifo #(
        .WIDTH (EW),
        .DEPTH (ODEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (out_en),
        .push_data_i ({addr_out, io_out}),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign fifo_pop          = m_ready && !fifo_empty;
    assign fifo_drop         = out_en && fifo_full && !fifo_pop;
    assign m_valid           = (fifo_count != '0);
    assign {m_addr, m_data}  = fifo_head;
    assign ovf               = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            ovf_q <= 1'b0;
        else if (fifo_drop) ovf_q <= 1'b1;
    end

    // A pending read of the same port frees its slot, so the producer need not stall.
    assign s_ready = !fresh_q[s_addr] || (req_in && (addr_in == s_addr));
    assign s_fire  = s_valid && s_ready;
    assign io_in   = hold_q[addr_in];
    assign fresh   = fresh_q;

    always_comb begin
        hold_d  = hold_q;
        fresh_d = fresh_q;
        if (req_in) fresh_d[addr_in] = 1'b0;
        if (s_fire) begin
            hold_d[s_addr]  = s_data;
            fresh_d[s_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q  <= '{default: '0};
            fresh_q <= '0;
        end else begin
            hold_q  <= hold_d;
            fresh_q <= fresh_d;
        end
    end

`ifdef IO_BRIDGE_ITR_EN
    logic itr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) itr_q <= 1'b0;
        else     itr_q <= s_fire;
    end

    assign itr = itr_q;
`else
    assign itr = 1'b0;
`endif

endmodule

// File: tb/tb_io_bridge.sv
// Directed, table-driven bench for io_bridge: output FIFO, holding registers, reset, interrupt.
module tb_io_bridge;

    logic        clk;
    logic        rst;
    logic [15:0] io_out;
    logic [1:0]  addr_out;
    logic        out_en;
    logic [15:0] io_in;
    logic [1:0]  addr_in;
    logic        req_in;
    logic [15:0] m_data;
    logic [1:0]  m_addr;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] s_data;
    logic [1:0]  s_addr;
    logic        s_valid;
    logic        s_ready;
    logic [3:0]  fresh;
    logic        ovf;
    logic        itr;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        logic        outEn;
        logic [1:0]  addrOut;
        logic [15:0] ioOut;
        logic        mReady;
        logic        reqIn;
        logic [1:0]  addrIn;
        logic        sValid;
        logic [1:0]  sAddr;
        logic [15:0] sData;
        logic        expMValid;
        logic [1:0]  expMAddr;
        logic [15:0] expMData;
        logic        expSReady;
        logic [15:0] expIoIn;
        logic [3:0]  expFresh;
        logic        expOvf;
        logic        expItrIfEn;
    } vec_t;

    vec_t vecs[$];

    io_bridge dut (
        .clk      (clk),
        .rst      (rst),
        .io_out   (io_out),
        .addr_out (addr_out),
        .out_en   (out_en),
        .io_in    (io_in),
        .addr_in  (addr_in),
        .req_in   (req_in),
        .m_data   (m_data),
        .m_addr   (m_addr),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .s_data   (s_data),
        .s_addr   (s_addr),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .fresh    (fresh),
        .ovf      (ovf),
        .itr      (itr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(
        input logic oe, input logic [1:0] ao, input logic [15:0] od, input logic mr,
        input logic rq, input logic [1:0] ai, input logic sv, input logic [1:0] sa, input logic [15:0] sd,
        input logic emv, input logic [1:0] ema, input logic [15:0] emd, input logic esr,
        input logic [15:0] eio, input logic [3:0] efr, input logic eov, input logic eit);
        vec_t v;
        v.outEn = oe; v.addrOut = ao; v.ioOut = od; v.mReady = mr;
        v.reqIn = rq; v.addrIn = ai; v.sValid = sv; v.sAddr = sa; v.sData = sd;
        v.expMValid = emv; v.expMAddr = ema; v.expMData = emd; v.expSReady = esr;
        v.expIoIn = eio; v.expFresh = efr; v.expOvf = eov; v.expItrIfEn = eit;
        return v;
    endfunction

    // Interrupt is only generated in the feature build; otherwise it must stay low.
    function automatic logic expItr(input logic whenEnabled);
`ifdef IO_BRIDGE_ITR_EN
        return whenEnabled;
`else
        return 1'b0 & whenEnabled;
`endif
    endfunction

    task automatic checkVal(input string name, input int idx, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s (step %0d): got %0h, expected %0h", name, idx, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        out_en   = v.outEn;
        addr_out = v.addrOut;
        io_out   = v.ioOut;
        m_ready  = v.mReady;
        req_in   = v.reqIn;
        addr_in  = v.addrIn;
        s_valid  = v.sValid;
        s_addr   = v.sAddr;
        s_data   = v.sData;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        @(negedge clk);
        checkVal("m_valid", idx, 32'(m_valid), 32'(v.expMValid));
        if (v.expMValid) begin
            checkVal("m_addr", idx, 32'(m_addr), 32'(v.expMAddr));
            checkVal("m_data", idx, 32'(m_data), 32'(v.expMData));
        end
        checkVal("s_ready", idx, 32'(s_ready), 32'(v.expSReady));
        checkVal("io_in",   idx, 32'(io_in),   32'(v.expIoIn));
        checkVal("fresh",   idx, 32'(fresh),   32'(v.expFresh));
        checkVal("ovf",     idx, 32'(ovf),     32'(v.expOvf));
        checkVal("itr",     idx, 32'(itr),     32'(expItr(v.expItrIfEn)));
    endtask

    task automatic checkReset(input int idx);
        checkVal("rst m_valid", idx, 32'(m_valid), 32'd0);
        checkVal("rst m_data",  idx, 32'(m_data),  32'd0);
        checkVal("rst m_addr",  idx, 32'(m_addr),  32'd0);
        checkVal("rst fresh",   idx, 32'(fresh),   32'd0);
        checkVal("rst ovf",     idx, 32'(ovf),     32'd0);
        checkVal("rst itr",     idx, 32'(itr),     32'd0);
        checkVal("rst io_in",   idx, 32'(io_in),   32'd0);
        checkVal("rst s_ready", idx, 32'(s_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        out_en = 0; addr_out = 0; io_out = 0; m_ready = 0;
        req_in = 0; addr_in = 0; s_valid = 0; s_addr = 0; s_data = 0;

        // Basic output word, then full FIFO with simultaneous push/pop, then overflow.
        vecs.push_back(mkVec(1,1,16'h1234,1, 0,0,0,0,0, 0,0,0,1,0,0,0,0));
        vecs.push_back(mkVec(0,0,0,1,        0,0,0,0,0, 1,1,16'h1234,1,0,0,0,0));
        vecs.push_back(mkVec(0,0,0,1,        0,0,0,0,0, 0,0,0,1,0,0,0,0));
        vecs.push_back(mkVec(1,0,16'hA001,0, 0,0,0,0,0, 0,0,0,1,0,0,0,0));
        vecs.push_back(mkVec(1,1,16'hA002,0, 0,0,0,0,0, 1,0,16'hA001,1,0,0,0,0));
        vecs.push_back(mkVec(1,2,16'hA003,0, 0,0,0,0,0, 1,0,16'hA001,1,0,0,0,0));
        vecs.push_back(mkVec(1,3,16'hA004,0, 0,0,0,0,0, 1,0,16'hA001,1,0,0,0,0));
        vecs.push_back(mkVec(1,1,16'hA005,1, 0,0,0,0,0, 1,0,16'hA001,1,0,0,0,0));
        vecs.push_back(mkVec(0,0,0,0,        0,0,0,0,0, 1,1,16'hA002,1,0,0,0,0));
        vecs.push_back(mkVec(0,0,0,1,        0,0,0,0,0, 1,1,16'hA002,1,0,0,0,0));
        vecs.push_back(mkVec(0,0,0,1,        0,0,0,0,0, 1,2,16'hA003,1,0,0,0,0));
        vecs.push_back(mkVec(0,0,0,1,        0,0,0,0,0, 1,3,16'hA004,1,0,0,0,0));
        vecs.push_back(mkVec(0,0,0,1,        0,0,0,0,0, 1,1,16'hA005,1,0,0,0,0));
        vecs.push_back(mkVec(0,0,0,1,        0,0,0,0,0, 0,0,0,1,0,0,0,0));
        vecs.push_back(mkVec(1,2,16'h0001,0, 0,0,0,0,0, 0,0,0,1,0,0,0,0));
        vecs.push_back(mkVec(1,2,16'h0002,0, 0,0,0,0,0, 1,2,16'h0001,1,0,0,0,0));
        vecs.push_back(mkVec(1,2,16'h0003,0, 0,0,0,0,0, 1,2,16'h0001,1,0,0,0,0));
        vecs.push_back(mkVec(1,2,16'h0004,0, 0,0,0,0,0, 1,2,16'h0001,1,0,0,0,0));
        vecs.push_back(mkVec(1,2,16'h0005,0, 0,0,0,0,0, 1,2,16'h0001,1,0,0,0,0));
        vecs.push_back(mkVec(0,0,0,1,        0,0,0,0,0, 1,2,16'h0001,1,0,0,1,0));
        vecs.push_back(mkVec(0,0,0,1,        0,0,0,0,0, 1,2,16'h0002,1,0,0,1,0));
        vecs.push_back(mkVec(0,0,0,1,        0,0,0,0,0, 1,2,16'h0003,1,0,0,1,0));
        vecs.push_back(mkVec(0,0,0,1,        0,0,0,0,0, 1,2,16'h0004,1,0,0,1,0));
        vecs.push_back(mkVec(0,0,0,1,        0,0,0,0,0, 0,0,0,1,0,0,1,0));
        // Inbound load/read, back-pressure, same-cycle read and load, back-to-back accepts.
        vecs.push_back(mkVec(0,0,0,0, 0,2,1,2,16'hBEEF, 0,0,0,1,16'h0000,4'b0000,1,0));
        vecs.push_back(mkVec(0,0,0,0, 1,2,0,2,16'h0000, 0,0,0,1,16'hBEEF,4'b0100,1,1));
        vecs.push_back(mkVec(0,0,0,0, 0,2,0,3,16'h0000, 0,0,0,1,16'hBEEF,4'b0000,1,0));
        vecs.push_back(mkVec(0,0,0,0, 0,2,1,3,16'h1111, 0,0,0,1,16'hBEEF,4'b0000,1,0));
        vecs.push_back(mkVec(0,0,0,0, 0,3,1,3,16'h2222, 0,0,0,0,16'h1111,4'b1000,1,1));
        vecs.push_back(mkVec(0,0,0,0, 1,3,1,3,16'h2222, 0,0,0,1,16'h1111,4'b1000,1,0));
        vecs.push_back(mkVec(0,0,0,0, 0,3,0,3,16'h0000, 0,0,0,0,16'h2222,4'b1000,1,1));
        vecs.push_back(mkVec(0,0,0,0, 0,1,1,1,16'h3333, 0,0,0,1,16'h0000,4'b1000,1,0));
        vecs.push_back(mkVec(0,0,0,0, 0,1,1,0,16'h4444, 0,0,0,1,16'h3333,4'b1010,1,1));
        vecs.push_back(mkVec(0,0,0,0, 0,1,0,0,16'h0000, 0,0,0,0,16'h3333,4'b1011,1,1));

        #2;
        $display("[TB] checking power-on reset state");
        checkReset(-1);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        // Queue one outbound word with unread inbound data present, then reset asynchronously.
        @(posedge clk);
        #1;
        out_en = 1; addr_out = 3; io_out = 16'h5A5A; m_ready = 0;
        req_in = 0; addr_in = 3; s_valid = 0; s_addr = 3; s_data = 0;
        @(posedge clk);
        #1;
        out_en = 0;
        @(negedge clk);
        checkVal("pre-rst m_valid", 100, 32'(m_valid), 32'd1);
        checkVal("pre-rst m_data",  100, 32'(m_data),  32'h5A5A);
        checkVal("pre-rst io_in",   100, 32'(io_in),   32'h2222);
        checkVal("pre-rst ovf",     100, 32'(ovf),     32'd1);
        #2;
        rst = 1'b1;
        #1;
        $display("[TB] checking asynchronous mid-stream reset");
        checkReset(101);
        @(negedge clk);
        rst = 1'b0;
        m_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVal("post-rst m_valid", 102, 32'(m_valid), 32'd0);
        checkVal("post-rst fresh",   102, 32'(fresh),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
